// File: rtl/team_06_i2s_pkg.sv
// Shared types, default constants and slot-mapping helpers for the I2S transmitter.
package team_06_i2s_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} i2s_state_t;

    localparam int I2S_SAMPLE_W = 8;
    localparam int I2S_SLOT_W   = 16;
    localparam int I2S_BCLK_DIV = 4;

    // Widest frame the helpers accept; callers zero-extend into this.
    localparam int SLOT_MAX_W   = 32;

    // Left-justified, zero-padded slot mapping: slot bit k of a sample_w-wide frame.
    function automatic logic slot_bit(input logic [SLOT_MAX_W-1:0] frame,
                                      input int                    k,
                                      input int                    sample_w);
        logic [4:0] idx;
        idx = 5'(sample_w - 1 - k);
        if (k < sample_w) return frame[idx];
        return 1'b0;
    endfunction

    // WS leads the slot MSB by one BCLK.
    function automatic logic ws_bit(input int b, input int slot_w);
        return (b >= slot_w - 1) && (b <= 2 * slot_w - 2);
    endfunction

endpackage

// File: rtl/team_06_i2s_bclk_gen.sv
// BCLK divider: toggles i2s_bclk every BCLK_DIV spiclk cycles while enabled and
// flags the cycle on which each edge is produced.
module team_06_i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic spiclk,
    input  logic rst,
    input  logic en,
    output logic i2s_bclk,
    output logic fall_evt,
    output logic rise_evt
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap     = en && (div_cnt == DW'(BCLK_DIV - 1));
    assign fall_evt = wrap && i2s_bclk;
    assign rise_evt = wrap && !i2s_bclk;

    always_ff @(posedge spiclk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (!en) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/team_06_i2s_tx.sv
// Mono I2S transmitter: each captured ADC sample fills both slots of a Philips frame.
// Optional macro TEAM_06_I2S_SIGNED_CONV_EN: offset-binary to two's-complement at capture.
module team_06_i2s_tx
    import team_06_i2s_pkg::*;
#(
    parameter int SAMPLE_W = I2S_SAMPLE_W,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int BCLK_DIV = I2S_BCLK_DIV
) (
    input  logic                spiclk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                i2s_bclk,
    output logic                i2s_ws,
    output logic                i2s_sd,
    output logic                overrun,
    output logic                underrun,
    output logic                busy
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int BW         = $clog2(FRAME_BITS);

    i2s_state_t          state_q, state_d;
    logic [BW-1:0]       bit_cnt, bit_nxt;
    logic [SAMPLE_W-1:0] frame_reg, hold_reg, frame_nxt, sample_cv;
    logic                hold_full;
    logic                fall_evt, rise_evt;
    logic                load;
    logic                ws_nxt, sd_nxt, sd_first;

`ifdef TEAM_06_I2S_SIGNED_CONV_EN
    assign sample_cv = {~sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-2:0]};
`else
    assign sample_cv = sample_in;
`endif

    team_06_i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .spiclk   (spiclk),
        .rst      (rst),
        .en       (state_q == RUN),
        .i2s_bclk (i2s_bclk),
        .fall_evt (fall_evt),
        .rise_evt (rise_evt)
    );

    assign bit_nxt = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    assign load    = fall_evt && (bit_cnt == BW'(FRAME_BITS - 1));

    // A sample arriving on the load cycle goes straight into the frame.
    always_comb begin
        frame_nxt = frame_reg;
        if (load) begin
            if (sample_valid)   frame_nxt = sample_cv;
            else if (hold_full) frame_nxt = hold_reg;
        end
    end

    always_comb begin
        int k;
        k        = int'(bit_nxt) % SLOT_W;
        ws_nxt   = ws_bit(int'(bit_nxt), SLOT_W);
        sd_nxt   = slot_bit(SLOT_MAX_W'(frame_nxt), k, SAMPLE_W);
        sd_first = slot_bit(SLOT_MAX_W'(sample_cv), 0, SAMPLE_W);
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q == RUN);
        case (state_q)
            IDLE:    if (sample_valid) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge spiclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt   <= '0;
            frame_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            i2s_ws    <= 1'b0;
            i2s_sd    <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (sample_valid) begin
                    frame_reg <= sample_cv;
                    bit_cnt   <= '0;
                    i2s_ws    <= 1'b0;
                    i2s_sd    <= sd_first;
                end
            end else begin
                if (fall_evt) begin
                    bit_cnt   <= bit_nxt;
                    frame_reg <= frame_nxt;
                    i2s_ws    <= ws_nxt;
                    i2s_sd    <= sd_nxt;
                    if (load && !sample_valid && !hold_full) underrun <= 1'b1;
                end
                if (load) begin
                    hold_full <= 1'b0;
                end else if (sample_valid) begin
                    hold_reg  <= sample_cv;
                    hold_full <= 1'b1;
                    if (hold_full) overrun <= 1'b1;
                end
            end
        end
    end

    // BCLK edges never coincide and only occur while streaming.
    a_evt_run: assert property (@(posedge spiclk) disable iff (rst)
        (rise_evt || fall_evt) |-> (state_q == RUN && !(rise_evt && fall_evt)));

endmodule

// File: tb/tb_team_06_i2s_tx.sv
// Scoreboard bench: expected (ws,sd) bits queued per frame, checked on each rising BCLK.
module tb_team_06_i2s_tx;

    logic       spiclk = 1'b0;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       i2s_bclk, i2s_ws, i2s_sd, overrun, underrun, busy;

    int errors = 0;
    int checks = 0;

    always #5 spiclk = ~spiclk;

    team_06_i2s_tx #(.SAMPLE_W(8), .SLOT_W(16), .BCLK_DIV(2)) dut (
        .spiclk       (spiclk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .i2s_bclk     (i2s_bclk),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .overrun      (overrun),
        .underrun     (underrun),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] conv(input logic [7:0] s);
`ifdef TEAM_06_I2S_SIGNED_CONV_EN
        return s ^ 8'h80;
`else
        return s;
`endif
    endfunction

    // Scoreboard of {ws, sd} per BCLK period
    logic [1:0] exp_q[$];
    int         bit_idx = 0;

    task automatic push_frame(input logic [7:0] v);
        for (int b = 0; b < 32; b++) begin
            int   k;
            logic ws, sd;
            k  = b % 16;
            ws = (b >= 15) && (b <= 30);
            sd = (k < 8) ? v[7-k] : 1'b0;
            exp_q.push_back({ws, sd});
        end
    endtask

    // Behavioural model of hold/frame handling
    int         cyc = 0;
    bit         push_en = 1'b0;
    logic [7:0] m_frame, m_hold;
    bit         m_full, m_over, m_under;

    task automatic model_reset();
        m_frame = '0; m_hold = '0; m_full = 0; m_over = 0; m_under = 0;
    endtask

    // One spiclk; the model sees the inputs driven for this edge.
    task automatic tick();
        @(posedge spiclk);
        cyc++;
        if (push_en) begin
            if (cyc % 128 == 0) begin
                if (sample_valid)  begin m_frame = conv(sample_in); m_full = 0; end
                else if (m_full)   begin m_frame = m_hold;          m_full = 0; end
                else               m_under = 1;
                push_frame(m_frame);
            end else if (sample_valid) begin
                if (m_full) m_over = 1;
                m_hold = conv(sample_in);
                m_full = 1;
            end
        end
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Sample accepted on edge n
    task automatic send_at(input int n, input logic [7:0] d);
        run_to(n - 1);
        sample_in    = d;
        sample_valid = 1'b1;
        tick();
    endtask

    // First sample from IDLE; that edge becomes cycle 0.
    task automatic start_stream(input logic [7:0] d);
        sample_in    = d;
        sample_valid = 1'b1;
        @(posedge spiclk);
        #1;
        sample_valid = 1'b0;
        cyc     = 0;
        push_en = 1'b1;
        m_frame = conv(d);
        push_frame(m_frame);
    endtask

    // Monitor: DAC-side view on rising BCLK
    logic prev_bclk = 1'b0;
    int   per_cnt   = 0;
    bit   have_rise = 1'b0;

    always @(negedge spiclk) begin
        if (rst) begin
            prev_bclk = 1'b0;
            per_cnt   = 0;
            have_rise = 1'b0;
        end else begin
            per_cnt++;
            if (i2s_bclk && !prev_bclk) begin
                if (have_rise) chk("bclk_period", per_cnt, 4);
                per_cnt   = 0;
                have_rise = 1'b1;
                if (exp_q.size() > 0) begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    chk($sformatf("ws_sd_bit%0d", bit_idx % 32), {30'd0, i2s_ws, i2s_sd}, {30'd0, e});
                    bit_idx++;
                end
            end
            prev_bclk = i2s_bclk;
        end
    end

    initial begin
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge spiclk);
        #1;
        chk("reset_outs", {26'd0, i2s_bclk, i2s_ws, i2s_sd, overrun, underrun, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge spiclk);
        #1;
        chk("idle_no_valid_busy", busy, 0);
        chk("idle_bclk", i2s_bclk, 0);

        // Frame 1: 0xA7, MSB visible one spiclk after the strobe
        start_stream(8'hA7);
        chk("latency_sd", i2s_sd, conv(8'hA7) >> 7);
        chk("latency_ws", i2s_ws, 0);
        chk("busy_run", busy, 1);

        // Frame 2: nothing new -> repeat and underrun from the load
        run_to(127);
        chk("underrun_before_load", underrun, 0);
        run_to(128);
        chk("underrun_at_load", underrun, m_under);

        // Frame 3: hold 0x11, then 0xD6 exactly on the load edge -> bypass
        send_at(200, 8'h11);
        send_at(256, 8'hD6);
        chk("bypass_overrun", overrun, 0);

        // Frame 5: two samples within frame 4 -> last wins, overrun
        send_at(400, 8'h11);
        chk("overrun_single", overrun, 0);
        send_at(420, 8'h22);
        chk("overrun_set", overrun, m_over);
        run_to(512);
        push_en = 1'b0;
        run_to(700);
        chk("queue_drained", exp_q.size(), 0);
        chk("overrun_sticky", overrun, 1);
        chk("underrun_sticky", underrun, 1);

        // Asynchronous reset in the middle of a frame
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outs", {26'd0, i2s_bclk, i2s_ws, i2s_sd, overrun, underrun, busy}, 32'd0);
        #14;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        bit_idx = 0;
        repeat (10) @(posedge spiclk);
        #1;
        chk("post_reset_idle", {30'd0, busy, i2s_bclk}, 32'd0);

        // Restart after reset with a new sample
        start_stream(8'h5A);
        chk("restart_latency_sd", i2s_sd, conv(8'h5A) >> 7);
        push_en = 1'b0;
        run_to(127);
        chk("restart_underrun", underrun, 0);
        chk("restart_overrun", overrun, 0);
        run_to(140);
        chk("restart_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
